// File: rtl/dct4x4_ctrl.sv
// Two-pass 4x4 forward DCT sequencer: drives a shared 4-point butterfly core
// for rows then columns, with a transpose buffer and a valid/ready output port.
module dct4x4_ctrl #(
    parameter int IN_W   = 10,
    parameter int CORE_X = 16,
    parameter int CORE_Y = 24,
    parameter int OUT_W  = 16,
    parameter int SHIFT1 = 1,
    parameter int SHIFT2 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_x0,
    input  logic signed [IN_W-1:0]   in_x1,
    input  logic signed [IN_W-1:0]   in_x2,
    input  logic signed [IN_W-1:0]   in_x3,
    output logic                     core_load,
    output logic signed [CORE_X-1:0] core_x0,
    output logic signed [CORE_X-1:0] core_x1,
    output logic signed [CORE_X-1:0] core_x2,
    output logic signed [CORE_X-1:0] core_x3,
    input  logic signed [CORE_Y-1:0] core_y0,
    input  logic signed [CORE_Y-1:0] core_y1,
    input  logic signed [CORE_Y-1:0] core_y2,
    input  logic signed [CORE_Y-1:0] core_y3,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_c0,
    output logic signed [OUT_W-1:0]  out_c1,
    output logic signed [OUT_W-1:0]  out_c2,
    output logic signed [OUT_W-1:0]  out_c3,
    output logic                     out_last
);

    typedef enum logic [2:0] {
        ST_ROW,
        ST_DRAIN1,
        ST_COL,
        ST_DRAIN2,
        ST_OUT
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_cnt;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic                     r_tag_vld_p0;
    logic                     r_tag_vld_p1;
    logic [1:0]               r_tag_idx_p0;
    logic [1:0]               r_tag_idx_p1;
    logic                     r_tag_pass_p0;
    logic                     r_tag_pass_p1;

    logic signed [CORE_X-1:0] r_t   [4][4];
    logic signed [OUT_W-1:0]  r_res [4][4];

    logic                     w_accept;
    logic                     w_load;
    logic signed [CORE_X-1:0] w_x  [4];
    logic signed [IN_W-1:0]   w_in [4];
    logic signed [CORE_Y-1:0] w_y  [4];

    // Round half up (add 2^(sh-1), floor shift) then saturate to a w-bit signed range.
    function automatic logic signed [CORE_Y:0] f_rnd_clip(
        input logic signed [CORE_Y-1:0] y,
        input int                       sh,
        input int                       w
    );
        logic signed [CORE_Y:0] v_one;
        logic signed [CORE_Y:0] v_ext;
        logic signed [CORE_Y:0] v_max;
        logic signed [CORE_Y:0] v_min;
        v_one = (CORE_Y+1)'(1);
        v_ext = {y[CORE_Y-1], y};
        v_ext = (v_ext + (v_one <<< (sh - 1))) >>> sh;
        v_max = (v_one <<< (w - 1)) - v_one;
        v_min = ~v_max;
        if (v_ext > v_max) begin
            v_ext = v_max;
        end else if (v_ext < v_min) begin
            v_ext = v_min;
        end
        return v_ext;
    endfunction

    assign w_in[0] = in_x0;
    assign w_in[1] = in_x1;
    assign w_in[2] = in_x2;
    assign w_in[3] = in_x3;
    assign w_y[0]  = core_y0;
    assign w_y[1]  = core_y1;
    assign w_y[2]  = core_y2;
    assign w_y[3]  = core_y3;

    assign w_accept = (r_state == ST_ROW) && r_in_ready && in_valid;

    always_comb begin
        w_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_x[i] = '0;
        end
        if (w_accept) begin
            w_load = 1'b1;
            for (int i = 0; i < 4; i++) begin
                w_x[i] = CORE_X'(w_in[i]);
            end
        end else if (r_state == ST_COL) begin
            w_load = 1'b1;
            for (int i = 0; i < 4; i++) begin
                w_x[i] = r_t[i][r_cnt];
            end
        end
    end

    // r_cnt is shared: row index, drain timer, column index, output row index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ROW;
            r_cnt       <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ROW: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state    <= ST_DRAIN1;
                            r_cnt      <= 2'd0;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAIN1: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state <= ST_COL;
                        r_cnt   <= 2'd0;
                    end
                end
                ST_COL: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= ST_DRAIN2;
                        r_cnt   <= 2'd0;
                    end
                end
                ST_DRAIN2: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state     <= ST_OUT;
                        r_cnt       <= 2'd0;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state     <= ST_ROW;
                            r_cnt       <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_ROW;
                    r_cnt       <= 2'd0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline: p1 marks the cycle in which the core output for that load is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld_p0  <= 1'b0;
            r_tag_vld_p1  <= 1'b0;
            r_tag_idx_p0  <= 2'd0;
            r_tag_idx_p1  <= 2'd0;
            r_tag_pass_p0 <= 1'b0;
            r_tag_pass_p1 <= 1'b0;
        end else begin
            r_tag_vld_p0  <= w_load;
            r_tag_idx_p0  <= r_cnt;
            r_tag_pass_p0 <= (r_state == ST_COL);
            r_tag_vld_p1  <= r_tag_vld_p0;
            r_tag_idx_p1  <= r_tag_idx_p0;
            r_tag_pass_p1 <= r_tag_pass_p0;
        end
    end

    // Capture stage: pass 1 fills transpose row r, pass 2 fills result column c.
    always_ff @(posedge clk) begin
        if (r_tag_vld_p1) begin
            for (int i = 0; i < 4; i++) begin
                if (!r_tag_pass_p1) begin
                    r_t[r_tag_idx_p1][i] <= CORE_X'(f_rnd_clip(w_y[i], SHIFT1, CORE_X));
                end else begin
                    r_res[i][r_tag_idx_p1] <= OUT_W'(f_rnd_clip(w_y[i], SHIFT2, OUT_W));
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign core_load = w_load;
    assign core_x0   = w_x[0];
    assign core_x1   = w_x[1];
    assign core_x2   = w_x[2];
    assign core_x3   = w_x[3];
    assign out_valid = r_out_valid;
    assign out_last  = r_out_valid && (r_cnt == 2'd3);
    assign out_c0    = r_out_valid ? r_res[r_cnt][0] : '0;
    assign out_c1    = r_out_valid ? r_res[r_cnt][1] : '0;
    assign out_c2    = r_out_valid ? r_res[r_cnt][2] : '0;
    assign out_c3    = r_out_valid ? r_res[r_cnt][3] : '0;

endmodule

// File: tb/tb_dct4x4_ctrl.sv
// Bench for dct4x4_ctrl: behavioural butterfly core plus a matrix-level
// reference of the full two-pass transform; directed and random blocks.
module tb_dct4x4_ctrl;
    localparam int IN_W   = 10;
    localparam int CORE_X = 16;
    localparam int CORE_Y = 24;
    localparam int OUT_W  = 16;
    localparam int SHIFT1 = 1;
    localparam int SHIFT2 = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, core_load, out_valid, out_ready, out_last;
    logic signed [IN_W-1:0]   in_x0, in_x1, in_x2, in_x3;
    logic signed [CORE_X-1:0] core_x0, core_x1, core_x2, core_x3;
    logic signed [CORE_Y-1:0] core_y0, core_y1, core_y2, core_y3;
    logic signed [OUT_W-1:0]  out_c0, out_c1, out_c2, out_c3;
    logic signed [OUT_W-1:0]  oc [4];

    always #5 clk = ~clk;

    dct4x4_ctrl #(
        .IN_W(IN_W), .CORE_X(CORE_X), .CORE_Y(CORE_Y),
        .OUT_W(OUT_W), .SHIFT1(SHIFT1), .SHIFT2(SHIFT2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
        .core_load(core_load),
        .core_x0(core_x0), .core_x1(core_x1), .core_x2(core_x2), .core_x3(core_x3),
        .core_y0(core_y0), .core_y1(core_y1), .core_y2(core_y2), .core_y3(core_y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
        .out_last(out_last)
    );

    assign oc[0] = out_c0;
    assign oc[1] = out_c1;
    assign oc[2] = out_c2;
    assign oc[3] = out_c3;

    int M [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                     '{64, -64, -64, 64}, '{36, -83, 83, -36}};

    // Butterfly core: input register on load, output register every cycle.
    logic signed [CORE_X-1:0] cx_q [4];
    logic signed [CORE_Y-1:0] cy_q [4];
    always @(posedge clk) begin
        if (core_load) begin
            cx_q[0] <= core_x0;
            cx_q[1] <= core_x1;
            cx_q[2] <= core_x2;
            cx_q[3] <= core_x3;
        end
        for (int i = 0; i < 4; i++) begin
            cy_q[i] <= CORE_Y'(M[i][0] * cx_q[0] + M[i][1] * cx_q[1]
                             + M[i][2] * cx_q[2] + M[i][3] * cx_q[3]);
        end
    end
    assign core_y0 = cy_q[0];
    assign core_y1 = cy_q[1];
    assign core_y2 = cy_q[2];
    assign core_y3 = cy_q[3];

    int cyc = 0;
    int loads = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_load) loads <= loads + 1;
    end

    int errors = 0;
    int checks = 0;
    int blk [16];
    int exp_res [16];
    int t_acc0, t_out0, t_ready;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd_clip(input int v, input int s, input int w);
        int r, hi, lo;
        r  = (v + (1 << (s - 1))) >>> s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    // Reference: T = clip(round(M * row)), result column c = clip(round(M * T column c)).
    task automatic compute_ref();
        int t [16];
        int acc;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 4; i++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc += M[i][j] * blk[r*4+j];
                t[r*4+i] = rnd_clip(acc, SHIFT1, CORE_X);
            end
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 0;
                for (int j = 0; j < 4; j++) acc += M[i][j] * t[j*4+c];
                exp_res[i*4+c] = rnd_clip(acc, SHIFT2, OUT_W);
            end
    endtask

    // mode 0: back-to-back rows, 1: valid every other cycle, 2: random gaps.
    task automatic send_block(input int mode);
        int r = 0;
        int n = 0;
        int bad = 0;
        bit gap;
        while (r < 4 && n < 400) begin
            @(negedge clk);
            n++;
            gap = (mode == 1) ? (n % 2 == 0) : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_x0 = IN_W'(blk[r*4+0]);
                in_x1 = IN_W'(blk[r*4+1]);
                in_x2 = IN_W'(blk[r*4+2]);
                in_x3 = IN_W'(blk[r*4+3]);
            end
            #1;
            if (in_valid && in_ready) begin
                if (r == 0) t_acc0 = cyc;
                if (!core_load || core_x0 !== CORE_X'(blk[r*4+0]) || core_x1 !== CORE_X'(blk[r*4+1])
                    || core_x2 !== CORE_X'(blk[r*4+2]) || core_x3 !== CORE_X'(blk[r*4+3]))
                    bad++;
                r++;
            end else if (core_load) begin
                bad++;
            end
        end
        chk("rows_accepted", r, 4);
        chk("row_load_strobe", bad, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_block(input int bp_row, input int bp_len);
        int j = 0;
        int stall = 0;
        int n = 0;
        out_ready = 1'b1;
        while (j < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (out_valid) begin
                if (t_out0 < 0) t_out0 = cyc;
                out_ready = !(j == bp_row && stall < bp_len);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("out_r%0d_c%0d", j, k), oc[k], exp_res[j*4+k]);
                chk($sformatf("out_last_r%0d", j), out_last, (j == 3));
                if (!out_ready) begin
                    stall++;
                    chk("stall_in_ready", in_ready, 0);
                end else begin
                    j++;
                end
            end
        end
        chk("rows_delivered", j, 4);
        out_ready = 1'b1;
        @(negedge clk);
        t_ready = cyc;
        chk("no_extra_row", out_valid, 0);
        chk("in_ready_after_block", in_ready, 1);
    endtask

    task automatic run_block(input int mode, input int bp_row, input int bp_len, input bit timed);
        int l0;
        compute_ref();
        l0 = loads;
        t_out0 = -1;
        send_block(mode);
        recv_block(bp_row, bp_len);
        chk("load_count", loads - l0, 8);
        if (timed) begin
            chk("latency_out_valid", t_out0 - t_acc0, 12);
            chk("latency_in_ready", t_ready - t_acc0, 16);
        end
    endtask

    task automatic set_impulse();
        for (int i = 0; i < 16; i++) blk[i] = 0;
        blk[0] = 1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_x0 = '0; in_x1 = '0; in_x2 = '0; in_x3 = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_load", core_load, 0);
        chk("rst_core_x0", core_x0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_c0", out_c0, 0);
        rst = 1'b0;

        // DC, impulse, saturation
        for (int i = 0; i < 16; i++) blk[i] = 10;
        run_block(0, 0, 0, 1'b1);
        set_impulse();
        run_block(0, 0, 0, 1'b1);
        for (int i = 0; i < 16; i++) blk[i] = 511;
        run_block(0, 0, 0, 1'b1);

        // Input gaps
        for (int i = 0; i < 16; i++) blk[i] = 10;
        run_block(1, 0, 0, 1'b0);
        set_impulse();
        run_block(1, 0, 0, 1'b0);

        // Output backpressure at row 1
        set_impulse();
        run_block(0, 1, 5, 1'b0);

        // Random blocks, full range and small range
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 16; i++)
                blk[i] = (b % 2 == 0) ? int'($urandom_range(0, 1023)) - 512
                                      : int'($urandom_range(0, 40)) - 20;
            run_block(b % 3, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0);
        end

        // Reset in the middle of the column pass
        for (int i = 0; i < 16; i++) blk[i] = int'($urandom_range(0, 1023)) - 512;
        send_block(0);
        repeat (3) @(negedge clk);
        chk("midrst_in_col", core_load, 1);
        rst = 1'b1;
        #1;
        chk("midrst_core_load", core_load, 0);
        chk("midrst_core_x0", core_x0, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_impulse();
        run_block(0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dct4x4_ctrl.md
# dct4x4_ctrl

Sequencer for a 4x4 two-pass HEVC forward DCT built on one shared 4-point butterfly core (`load`, `x0..x3` in, registered `y0..y3` out).
- **Pass 1 (rows):** accepts four residual rows, drives them through the core, and rounds and clips the results into a transpose buffer.
- **Pass 2 (columns):** replays the buffer column-wise through the same core and stores the rounded, clipped coefficients.
- **Output:** presents the coefficient block row by row on a valid/ready port.

The block sits between the residual source and the quantizer. It owns the core's input side and reads the core's outputs.

## Interface
- `IN_W`, 10: residual sample width (signed).
- `CORE_X`, 16: core input width; also the intermediate (transpose) width.
- `CORE_Y`, 24: core output width.
- `OUT_W`, 16: coefficient width (signed).
- `SHIFT1`, 1: pass-1 rounding shift.
- `SHIFT2`, 8: pass-2 rounding shift.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: residual row valid.
- `in_ready` out 1: row accepted when `in_valid && in_ready`.
- `in_x0..in_x3` in `IN_W` each: residual row, signed.
- `core_load` out 1: core input-register load strobe.
- `core_x0..core_x3` out `CORE_X` each: core inputs.
- `core_y0..core_y3` in `CORE_Y` each: core registered outputs.
- `out_valid` out 1: coefficient row valid.
- `out_ready` in 1: downstream accepts the row.
- `out_c0..out_c3` out `OUT_W` each: coefficient row j, columns 0..3.
- `out_last` out 1: high with coefficient row 3.

## Operation
- **States:** ROW → DRAIN1 → COL → DRAIN2 → OUT → ROW.
- **ROW:**
  - `in_ready` = 1.
  - On each accepted row: `core_load` = 1 and `core_x*` = sign-extended `in_x*` (combinational).
  - Row counter r runs 0..3. After the 4th acceptance, go to DRAIN1.
  - Gaps in `in_valid` are allowed.
- **Capture tracking:** a 2-stage tag pipeline records each `core_load` together with its index and pass.
  - A load in cycle k implies `core_y*` is valid in cycle k+2.
  - Capture occurs at the end of cycle k+2.
- **Pass-1 capture:** `T[r][i] = clip_CORE_X((core_y_i + 2^(SHIFT1-1)) >>> SHIFT1)`.
- **DRAIN1:** wait until the row-3 capture completes (2 cycles), then go to COL.
- **COL:**
  - 4 consecutive cycles, column c = 0..3.
  - `core_load` = 1 and `core_x_i = T[i][c]`.
  - Then go to DRAIN2.
- **Pass-2 capture:** `R[i][c] = clip_OUT_W((core_y_i + 2^(SHIFT2-1)) >>> SHIFT2)`.
- **DRAIN2:** wait until the column-3 capture completes (2 cycles), then go to OUT.
- **OUT:**
  - `out_valid` = 1 with `out_c_k = R[j][k]`; j runs 0..3.
  - j advances on `out_valid && out_ready`.
  - `out_last` = (j == 3).
  - After the row-3 handshake, go to ROW with all counters at 0.
- **Arithmetic:**
  - `>>>` is an arithmetic shift (floor).
  - `clip_W` saturates to [-2^(W-1), 2^(W-1)-1].
- **Idle outputs:** `core_load` = 0 outside ROW-accept and COL cycles. `core_x*` = 0 when `core_load` = 0.

## Timing
- **Reset values:**
  - `in_ready` 0 while `rst` is high.
  - `core_load` 0; `core_x*` 0.
  - `out_valid` 0; `out_c*` 0; `out_last` 0.
  - State ROW; counters and tags cleared.
  - T and R contents don't-care.
- **Reset mid-operation:** any state returns to ROW immediately. The partial block is discarded. In-flight core results are ignored because the tags are cleared.
- **Minimum latency** (rows accepted in cycles 0..3):
  - DRAIN1 in cycles 4-5.
  - COL in cycles 6-9.
  - DRAIN2 in cycles 10-11.
  - `out_valid` first high in cycle 12.
- **Throughput:** with `out_ready` held at 1, row 3 is output in cycle 15 and `in_ready` is high again in cycle 16.
- **Output stability:** while `out_valid && !out_ready`, `out_c*` and `out_last` are held stable.
- **Backpressure:** `in_ready` stays 0 in all states other than ROW; rows arriving during a block are backpressured, never dropped.

## Test plan
- **DC block:** 4 rows of (10,10,10,10) → row 0 = (1280,0,0,0), rows 1-3 all zero, `out_last` on row 3, `out_valid` in cycle 12.
- **Impulse:** row 0 = (1,0,0,0), others zero → output rows (8,11,8,5), (10,14,10,6), (8,11,8,5), (5,6,5,3).
- **Saturation:** all samples 511 → pass-1 DC clipped to 32767, output row 0 = (32767,0,0,0), rest zero.
- **Input gaps:** `in_valid` toggling every other cycle → same results as the DC and impulse cases; `core_load` pulses only on accepted rows.
- **Output backpressure:** `out_ready` low for 5 cycles at row 1 → `out_valid` stays high, data stable, `in_ready` 0; all 4 rows then delivered exactly once.
- **Mid-block reset:** assert `rst` during COL → all outputs 0 immediately; after release, a new impulse block produces the exact impulse result.
